// File: rtl/sc_s2b_acc.sv
// sc_s2b_acc: stochastic-to-binary accumulator.
// Counts 1s on iBit over a 2^LOGLEN-cycle window and publishes the count
// scaled to INWD bits with a one-cycle oValid pulse. Windows start on 'start'.
// Optional macro SC_S2B_CONT_EN: re-arm automatically for back-to-back windows.
`ifndef INWD
`define INWD 8
`endif

module sc_s2b_acc #(
    parameter int INWD   = `INWD,
    parameter int LOGLEN = 2*INWD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            iBit,
    output logic [INWD-1:0] oVal,
    output logic            oValid,
    output logic            busy
);

    generate
        if (LOGLEN < INWD) begin : gBadLogLen
            $error("sc_s2b_acc: LOGLEN must be >= INWD");
        end
    endgenerate

`ifdef SC_S2B_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;

    stateT             state;
    stateT             nextState;
    logic [LOGLEN-1:0] winCnt;
    logic [LOGLEN:0]   onesCnt;
    logic [LOGLEN:0]   onesFinal;
    logic              lastEdge;

    // Top INWD bits of the (LOGLEN+1)-bit count; only an all-ones stream
    // sets the MSB, and that case clamps to full scale.
    function automatic logic [INWD-1:0] scaleSat(input logic [LOGLEN:0] ones);
        if (ones[LOGLEN])
            scaleSat = {INWD{1'b1}};
        else
            scaleSat = ones[LOGLEN-1 -: INWD];
    endfunction

    // The edge that samples the final bit of the window.
    assign lastEdge  = (state == RUN) && (winCnt == {LOGLEN{1'b1}});
    // Count including the bit sampled on this edge.
    assign onesFinal = onesCnt + {{LOGLEN{1'b0}}, iBit};
    assign busy      = (state == RUN);

    // Next-state: start always (re)enters RUN; completion leaves RUN unless continuous.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = RUN;
            RUN:  if (!start && lastEdge && !CONT) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Window counters: cleared on start or completion, advanced while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winCnt  <= '0;
            onesCnt <= '0;
        end else if (start || lastEdge) begin
            winCnt  <= '0;
            onesCnt <= '0;
        end else if (state == RUN) begin
            winCnt  <= winCnt + LOGLEN'(1);
            onesCnt <= onesFinal;
        end
    end

    // Result publication: oVal held between completions, oValid pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oVal   <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= lastEdge;
            if (lastEdge) oVal <= scaleSat(onesFinal);
        end
    end

endmodule

// File: tb/tb_sc_s2b_acc.sv
// Bench for sc_s2b_acc: directed windows, expected results queued at
// stimulus time and checked by independent monitors on each oValid.
`timescale 1ns/1ps

module tb_sc_s2b_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, iBit;
    logic       start16, iBit16;
    logic [7:0] oVal, oVal16;
    logic       oValid, oValid16;
    logic       busy, busy16;

    always #5 clk = ~clk;

    sc_s2b_acc #(.INWD(8), .LOGLEN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .iBit(iBit),
        .oVal(oVal), .oValid(oValid), .busy(busy)
    );

    sc_s2b_acc #(.INWD(8), .LOGLEN(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .iBit(iBit16),
        .oVal(oVal16), .oValid(oValid16), .busy(busy16)
    );

    typedef struct {
        logic [7:0] val;
        int         atEdge;
    } expT;

    expT q8[$];
    expT q16[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  edgeNo      = 0;

    always @(posedge clk) edgeNo <= edgeNo + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edgeNo);
        end
    endtask

    // Scoreboard monitor, 8-bit window instance.
    always @(negedge clk) begin
        expT e;
        if (rst === 1'b0 && oValid === 1'b1) begin
            vectors++;
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_oValid: oVal=%0d at edge %0d, no result pending", oVal, edgeNo);
            end else begin
                e = q8.pop_front();
                if (oVal !== e.val || edgeNo != e.atEdge) begin
                    miscompares++;
                    $display("FAIL result8: oVal=%0d at edge %0d, expected %0d at edge %0d",
                             oVal, edgeNo, e.val, e.atEdge);
                end
            end
        end
    end

    // Scoreboard monitor, 16-bit window instance.
    always @(negedge clk) begin
        expT e;
        if (rst === 1'b0 && oValid16 === 1'b1) begin
            vectors++;
            if (q16.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_oValid16: oVal=%0d at edge %0d, no result pending", oVal16, edgeNo);
            end else begin
                e = q16.pop_front();
                if (oVal16 !== e.val || edgeNo != e.atEdge) begin
                    miscompares++;
                    $display("FAIL result16: oVal=%0d at edge %0d, expected %0d at edge %0d",
                             oVal16, edgeNo, e.val, e.atEdge);
                end
            end
        end
    end

    // mode 0: zeros, 1: ones, 2: 1 on odd sampled cycles, 3: 1 every 4th.
    function automatic logic bitOf(input int mode, input int j);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (j % 2) == 1;
            default: return (j % 4) == 0;
        endcase
    endfunction

    // Called at a negedge; returns the edge number k that sampled start.
    task automatic doStart(output int k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = edgeNo;
    endtask

    task automatic feed(input int mode, input int n);
        for (int j = 1; j <= n; j++) begin
            iBit = bitOf(mode, j);
            @(negedge clk);
        end
        iBit = 1'b0;
    endtask

    // Return to IDLE between tests when the block re-arms itself.
    task automatic settle();
`ifdef SC_S2B_CONT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        @(negedge clk);
    endtask

    initial begin
        int k, k2;
        rst = 1'b1; start = 1'b0; iBit = 1'b0; start16 = 1'b0; iBit16 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_oVal", 32'(oVal), 0);
        check("reset_oValid", 32'(oValid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_busy16", 32'(busy16), 0);

        // All-ones window saturates to 255.
        doStart(k);
        q8.push_back('{8'd255, k + 256});
        check("busy_run", 32'(busy), 1);
        feed(1, 256);
`ifndef SC_S2B_CONT_EN
        check("busy_drop_ones", 32'(busy), 0);
`endif
        @(negedge clk);
        check("oValid_single", 32'(oValid), 0);
        check("oVal_held", 32'(oVal), 255);
        settle();

        // Reset mid-window clears everything; no result without a new start.
        doStart(k);
        feed(1, 50);
        rst = 1'b1;
        #1;
        check("rst_oVal", 32'(oVal), 0);
        check("rst_oValid", 32'(oValid), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        iBit = 1'b1;
        repeat (300) @(negedge clk);
        iBit = 1'b0;
        check("idle_after_rst_busy", 32'(busy), 0);
        check("idle_after_rst_oVal", 32'(oVal), 0);

        // All-zeros window.
        doStart(k);
        q8.push_back('{8'd0, k + 256});
        feed(0, 256);
`ifndef SC_S2B_CONT_EN
        check("busy_drop_zeros", 32'(busy), 0);
`endif
        settle();

        // Alternating bits, restart at sampled cycle 100.
        doStart(k);
        feed(2, 99);
        start = 1'b1;
        iBit = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k2 = edgeNo;
        q8.push_back('{8'd128, k2 + 256});
        check("busy_after_abort", 32'(busy), 1);
        feed(2, 156);
        check("no_valid_aborted", 32'(oValid), 0);
        feed(2, 100);
        settle();

        // Start coincident with the final edge: publish and run again.
        doStart(k);
        q8.push_back('{8'd255, k + 256});
        feed(1, 255);
        start = 1'b1;
        iBit = 1'b1;
        @(negedge clk);
        start = 1'b0;
        iBit = 1'b0;
        k2 = edgeNo;
        check("busy_back_to_back", 32'(busy), 1);
        q8.push_back('{8'd0, k2 + 256});
        feed(0, 256);
        settle();

`ifdef SC_S2B_CONT_EN
        // Continuous: two windows from a single start.
        doStart(k);
        q8.push_back('{8'd255, k + 256});
        q8.push_back('{8'd0, k + 512});
        feed(1, 256);
        check("cont_busy_mid", 32'(busy), 1);
        feed(0, 256);
        check("cont_busy_end", 32'(busy), 1);
        settle();
`endif

        // Long window: one in four bits set, 16384 ones -> 64.
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        k = edgeNo;
        q16.push_back('{8'd64, k + 65536});
        for (int j = 1; j <= 65536; j++) begin
            iBit16 = bitOf(3, j);
            @(negedge clk);
        end
        iBit16 = 1'b0;
`ifndef SC_S2B_CONT_EN
        check("busy16_drop", 32'(busy16), 0);
`endif
        check("oVal16_held", 32'(oVal16), 64);

        repeat (4) @(negedge clk);
        while (q8.size() > 0) begin
            expT e;
            e = q8.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_result8: no oValid seen, expected %0d at edge %0d", e.val, e.atEdge);
        end
        while (q16.size() > 0) begin
            expT e;
            e = q16.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_result16: no oValid seen, expected %0d at edge %0d", e.val, e.atEdge);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
